// File: rtl/io_tile_cfg_pkg.sv
// Shared configuration definitions for the physical IO tile: per-channel
// config bit layout, the chain FSM states and the decoded per-channel record.
package io_tile_cfg_pkg;

  // Config bits per channel and their position within the channel's slice.
  localparam int CFG_BITS_PER_IO = 3;
  localparam int CFG_DIR         = 0;
  localparam int CFG_OUT_INV     = 1;
  localparam int CFG_IN_INV      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ccff_state_t;

  // Field order puts dir at bit 0, matching the chain slice 3*i+k.
  typedef struct packed {
    logic in_inv;
    logic out_inv;
    logic dir;
  } io_cfg_t;

endpackage

// File: rtl/io_cfg_chain.sv
// Serial configuration chain with length-checked commit into a shadow
// register. The pads only ever see the shadow, so a frame can be shifted in
// while the previous configuration stays live.
module io_cfg_chain
  import io_tile_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = 12
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 ccff_head,
  input  logic                 ccff_en,
  input  logic                 cfg_load,
  output logic                 ccff_tail,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [CHAIN_LEN-1:0] shadow
);

  // One extra count above CHAIN_LEN so an overshifted frame never aliases
  // back to a valid length.
  localparam int                CNT_W    = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN + 1);

  ccff_state_t          state;
  ccff_state_t          state_nxt;
  logic [CHAIN_LEN-1:0] chain;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 start_frame;
  logic                 do_commit;
  logic                 set_err;

  // The last chain stage is already a flop, so the tail is registered and
  // lags the head by exactly CHAIN_LEN shifts.
  assign ccff_tail = chain[CHAIN_LEN-1];

  // State register.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge.
    if (prog_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state and control decode: frame start, commit and error events.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    state_nxt   = state;
    start_frame = 1'b0;
    do_commit   = 1'b0;
    set_err     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (ccff_en) begin
          state_nxt   = SHIFT;
          start_frame = 1'b1;
        end
        if (cfg_load) set_err = 1'b1;
      end
      SHIFT: begin
        if (cfg_load) begin
          if (ccff_en) begin
            set_err = 1'b1;
          end else if (bit_cnt == CNT_FULL) begin
            do_commit = 1'b1;
            state_nxt = DONE;
          end else begin
            set_err   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: a committed frame is held exactly while in DONE.
  always_comb begin
    cfg_done = (state == DONE);
  end

  // Chain shifting, bit counting, shadow commit and the sticky error flag.
  always_ff @(posedge prog_clk or posedge prog_reset) begin
    // NOTE: chain and shadow are register banks that do get reset, because
    // an all-zero shadow is what puts every pad into input mode.
    if (prog_reset) begin
      chain   <= '0;
      bit_cnt <= '0;
      shadow  <= '0;
      cfg_err <= 1'b0;
    end else begin
      if (ccff_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};

      if (start_frame)                       bit_cnt <= CNT_ONE;
      else if (ccff_en && bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_ONE;

      if (do_commit) shadow <= chain;

      if (set_err)        cfg_err <= 1'b1;
      else if (do_commit) cfg_err <= 1'b0;
    end
  end

endmodule

// File: rtl/logical_tile_io_mode_physical__iopad_array.sv
// Physical IO tile: NUM_IO GPIO pads configured from a serial chain. Each
// pad is driven from fabric data (optionally inverted) when its DIR bit is
// set, and is always read back into the fabric (optionally inverted).
module logical_tile_io_mode_physical__iopad_array
  import io_tile_cfg_pkg::*;
#(
  parameter int NUM_IO = 4
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              ccff_head,
  input  logic              ccff_en,
  input  logic              cfg_load,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_err,
  inout  wire  [NUM_IO-1:0] gfpga_pad_GPIO_PAD,
  input  logic [NUM_IO-1:0] iopad_outpad,
  output logic [NUM_IO-1:0] iopad_inpad
);

  localparam int CHAIN_LEN = CFG_BITS_PER_IO * NUM_IO;

  logic [CHAIN_LEN-1:0] shadow;

  io_cfg_chain #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_cfg_chain (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .ccff_head  (ccff_head),
    .ccff_en    (ccff_en),
    .cfg_load   (cfg_load),
    .ccff_tail  (ccff_tail),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .shadow     (shadow)
  );

  // Per-channel pad cell: tri-state driver with output inversion, plus an
  // always-on input path with its own inversion for loopback readback.
  for (genvar i = 0; i < NUM_IO; i++) begin : g_io
    io_cfg_t cfg;
    assign cfg = io_cfg_t'(shadow[CFG_BITS_PER_IO*i +: CFG_BITS_PER_IO]);
    assign gfpga_pad_GPIO_PAD[i] = cfg.dir ? (iopad_outpad[i] ^ cfg.out_inv) : 1'bz;
    assign iopad_inpad[i]        = gfpga_pad_GPIO_PAD[i] ^ cfg.in_inv;
  end

endmodule

// File: tb/tb_logical_tile_io_mode_physical__iopad_array.sv
// Scoreboard bench for the physical IO tile. The stimulus side steps a
// behavioural model of the configuration protocol and queues the expected
// outputs; a monitor on the falling edge pops and compares.
module tb_logical_tile_io_mode_physical__iopad_array;

  localparam int NUM_IO    = 4;
  localparam int CHAIN_LEN = 12;

  logic              prog_clk   = 1'b0;
  logic              prog_reset = 1'b1;
  logic              ccff_head  = 1'b0;
  logic              ccff_en    = 1'b0;
  logic              cfg_load   = 1'b0;
  logic              ccff_tail;
  logic              cfg_done;
  logic              cfg_err;
  wire  [NUM_IO-1:0] pad;
  logic [NUM_IO-1:0] outpad  = '0;
  logic [NUM_IO-1:0] inpad;
  logic              ext_oe  = 1'b0;
  logic [NUM_IO-1:0] ext_val = '0;

  // External device on the pads; it only drives when told to.
  assign pad = ext_oe ? ext_val : 4'bzzzz;

  always #5 prog_clk = ~prog_clk;

  logical_tile_io_mode_physical__iopad_array #(
    .NUM_IO (NUM_IO)
  ) dut (
    .prog_clk           (prog_clk),
    .prog_reset         (prog_reset),
    .ccff_head          (ccff_head),
    .ccff_en            (ccff_en),
    .cfg_load           (cfg_load),
    .ccff_tail          (ccff_tail),
    .cfg_done           (cfg_done),
    .cfg_err            (cfg_err),
    .gfpga_pad_GPIO_PAD (pad),
    .iopad_outpad       (outpad),
    .iopad_inpad        (inpad)
  );

  typedef struct {
    bit              tail;
    bit              done;
    bit              err;
    bit [NUM_IO-1:0] pad;
    bit [NUM_IO-1:0] inpad;
    bit [NUM_IO-1:0] mask;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  // Reference model: live per-channel config, the frame being collected,
  // the last CHAIN_LEN bits shifted since reset, and protocol flags.
  bit m_dir [NUM_IO];
  bit m_oinv[NUM_IO];
  bit m_iinv[NUM_IO];
  bit m_collecting;
  bit m_committed;
  bit m_err;
  bit m_frame[$];
  bit m_hist[$];

  // Overrides for the directed scenarios; random values otherwise.
  bit              fix_out = 1'b0;
  logic [NUM_IO-1:0] fix_out_val = '0;
  bit              fix_ext = 1'b0;
  logic [NUM_IO-1:0] fix_ext_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_IO; i++) begin
      m_dir[i]  = 1'b0;
      m_oinv[i] = 1'b0;
      m_iinv[i] = 1'b0;
    end
    m_collecting = 1'b0;
    m_committed  = 1'b0;
    m_err        = 1'b0;
    m_frame.delete();
    m_hist.delete();
    for (int i = 0; i < CHAIN_LEN; i++) m_hist.push_back(1'b0);
  endfunction

  // One clock of the configuration protocol, described in terms of the
  // frame collected so far rather than any counter or state encoding.
  function automatic void model_step(input bit en, input bit head, input bit load);
    int n;
    if (en) begin
      m_hist.push_back(head);
      void'(m_hist.pop_front());
      if (!m_collecting) begin
        m_frame.delete();
        m_collecting = 1'b1;
        m_committed  = 1'b0;
      end
      m_frame.push_back(head);
      if (load) m_err = 1'b1;
    end else if (load) begin
      n = m_frame.size();
      if (m_collecting && n == CHAIN_LEN) begin
        // Most recently shifted bit sits at chain index 0.
        for (int i = 0; i < NUM_IO; i++) begin
          m_dir[i]  = m_frame[n-1-(3*i+0)];
          m_oinv[i] = m_frame[n-1-(3*i+1)];
          m_iinv[i] = m_frame[n-1-(3*i+2)];
        end
        m_collecting = 1'b0;
        m_committed  = 1'b1;
        m_err        = 1'b0;
      end else begin
        m_collecting = 1'b0;
        m_err        = 1'b1;
      end
    end
  endfunction

  function automatic bit model_all_inputs();
    bit r = 1'b1;
    for (int i = 0; i < NUM_IO; i++) if (m_dir[i]) r = 1'b0;
    return r;
  endfunction

  // Expected outputs for the pads given the model and the present pad-side
  // stimulus. Bits that nobody drives, or that two sides drive, are masked.
  function automatic exp_t predict();
    exp_t e;
    e.tail  = m_hist[0];
    e.done  = m_committed;
    e.err   = m_err;
    e.pad   = '0;
    e.inpad = '0;
    e.mask  = '0;
    for (int i = 0; i < NUM_IO; i++) begin
      if (m_dir[i] && !ext_oe) begin
        e.mask[i] = 1'b1;
        e.pad[i]  = outpad[i] ^ m_oinv[i];
      end else if (!m_dir[i] && ext_oe) begin
        e.mask[i] = 1'b1;
        e.pad[i]  = ext_val[i];
      end
      e.inpad[i] = e.pad[i] ^ m_iinv[i];
    end
    return e;
  endfunction

  // One stimulus clock: inputs change just after the falling edge, the
  // model advances on the rising edge and the expectation is queued.
  task automatic cycle(input bit en, input bit head, input bit load, input bit rst);
    @(negedge prog_clk);
    #1;
    prog_reset = rst;
    ccff_en    = en;
    ccff_head  = head;
    cfg_load   = load;
    outpad     = fix_out ? fix_out_val : NUM_IO'($urandom);
    ext_oe     = model_all_inputs();
    ext_val    = fix_ext ? fix_ext_val : NUM_IO'($urandom);
    @(posedge prog_clk);
    if (rst) model_reset();
    else     model_step(en, head, load);
    sb.push_back(predict());
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n, input bit pauses);
    for (int i = n - 1; i >= 0; i--) begin
      if (pauses && $urandom_range(0, 3) == 0) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, w[i], 1'b0, 1'b0);
    end
  endtask

  task automatic load();
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset in the middle of a clock: outputs and pads must
  // release before the next rising edge.
  task automatic async_reset();
    @(negedge prog_clk);
    #1;
    prog_reset = 1'b1;
    ccff_en    = 1'b0;
    cfg_load   = 1'b0;
    model_reset();
    ext_oe     = 1'b1;
    ext_val    = 4'b0110;
    #1;
    check("async_rst_done", 32'(cfg_done), 32'(0));
    check("async_rst_err", 32'(cfg_err), 32'(0));
    check("async_rst_tail", 32'(ccff_tail), 32'(0));
    check("async_rst_pad_in_a", 32'(inpad), 32'(ext_val));
    ext_val = 4'b1001;
    #1;
    check("async_rst_pad_in_b", 32'(inpad), 32'(ext_val));
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge prog_clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check("ccff_tail", 32'(ccff_tail), 32'(cur.tail));
      check("cfg_done", 32'(cfg_done), 32'(cur.done));
      check("cfg_err", 32'(cfg_err), 32'(cur.err));
      check("pad", 32'(pad & cur.mask), 32'(cur.pad & cur.mask));
      check("inpad", 32'(inpad & cur.mask), 32'(cur.inpad & cur.mask));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Reset: pads released, all flags low.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Good load of 0x249: every channel output, no inversion.
    shift_bits(16'h0249, 12, 1'b0);
    load();
    fix_out = 1'b1; fix_out_val = 4'b1010;
    idle(2);
    fix_out = 1'b0;

    // Short frame: rejected, pads keep the previous config.
    shift_bits(16'(12'($urandom)), 11, 1'b0);
    load();
    idle(2);

    // Overshift: tail shows the first bit twelve shifts later; rejected.
    shift_bits(16'h1F35, 13, 1'b0);
    load();
    idle(1);

    // Reconfigure from DONE to inputs with output inversion.
    shift_bits(16'h0249, 12, 1'b0);
    load();
    shift_bits(16'h0492, 12, 1'b1);
    load();
    fix_ext = 1'b1; fix_ext_val = 4'b0011;
    idle(2);
    fix_ext = 1'b0;

    // Collision: shift taken, load rejected, still collecting.
    shift_bits(16'h0015, 5, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    shift_bits(16'h0003, 2, 1'b0);
    async_reset();
    // A full frame after reset must commit, so the count restarted.
    shift_bits(16'h0249, 12, 1'b1);
    load();
    idle(1);

    // Randomised protocol traffic.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: begin
          shift_bits(16'($urandom), 12, 1'b1);
          load();
        end
        3: begin
          shift_bits(16'($urandom), $urandom_range(1, 15), 1'b1);
          load();
        end
        4: load();
        5: cycle(1'b1, 1'($urandom), 1'b1, 1'b0);
        default: idle($urandom_range(1, 3));
      endcase
    end

    idle(2);
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge prog_clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
